// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  localparam int DEF_N_IN = 7;
  localparam int DEF_PIPE = 0;

  // One extra bit so a full sweep of 2^n_in hits can be counted without wrap.
  function automatic int cnt_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/tt_tag_pipe.sv
// Delay line for {valid, index} tags so captures line up with a pipelined netlist.
module tt_tag_pipe #(
  parameter int DEPTH = 0,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_index,
  output logic         o_valid,
  output logic [W-1:0] o_index
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{clk, rst_n, i_flush};
    assign o_valid  = i_valid;
    assign o_index  = i_index;
  end else begin : g_pipe
    logic         r_valid [DEPTH];
    logic [W-1:0] r_index [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_valid[k] <= 1'b0;
        end
      end else begin
        r_valid[0] <= i_valid;
        for (int k = 1; k < DEPTH; k++) begin
          r_valid[k] <= r_valid[k-1];
        end
      end
    end

    // Indices are only meaningful alongside a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
      r_index[0] <= i_index;
      for (int k = 1; k < DEPTH; k++) begin
        r_index[k] <= r_index[k-1];
      end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_index = r_index[DEPTH-1];
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweep over two single-output netlists, counting A's onset
// and A/B disagreements, and remembering the lowest disagreeing vector.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = DEF_N_IN,
  parameter int PIPE = DEF_PIPE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic [N_IN-1:0]               vec_o,
  input  logic                          y_a_i,
  input  logic                          y_b_i,
  output logic                          busy,
  output logic                          done,
  output logic                          res_valid,
  output logic [cnt_width(N_IN)-1:0]    onset_cnt,
  output logic [cnt_width(N_IN)-1:0]    mis_cnt,
  output logic                          mismatch,
  output logic [N_IN-1:0]               first_mis
);

  localparam int CW = cnt_width(N_IN);
  localparam int DW = $clog2(PIPE + 2);

  sweep_state_t      r_state;
  sweep_state_t      w_state_next;
  logic [N_IN-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic              r_res_valid;
  logic [CW-1:0]     r_onset;
  logic [CW-1:0]     r_mis;
  logic              r_mismatch;
  logic [N_IN-1:0]   r_first;
  logic [DW-1:0]     r_drain_cnt;

  logic              w_start_sweep;
  logic              w_flush;
  logic              w_last;
  logic              w_tag_valid;
  logic              w_cap_valid;
  logic [N_IN-1:0]   w_cap_index;
  logic              w_diff;

  assign w_last      = (r_vec == {N_IN{1'b1}});
  assign w_tag_valid = (r_state == ST_RUN);
  assign w_diff      = y_a_i ^ y_b_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_sweep = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next  = ST_RUN;
          w_start_sweep = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_flush      = 1'b1;
        end else if (w_last) begin
          w_state_next = (PIPE > 0) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_flush      = 1'b1;
        end else if (r_drain_cnt == '0) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_next  = ST_RUN;
          w_start_sweep = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_onset     <= '0;
      r_mis       <= '0;
      r_mismatch  <= 1'b0;
      r_first     <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_busy <= (w_state_next == ST_RUN) || (w_state_next == ST_DRAIN);
      r_done <= (w_state_next == ST_DONE);

      if (w_state_next == ST_DONE) begin
        r_res_valid <= 1'b1;
      end else if (w_start_sweep || w_flush) begin
        r_res_valid <= 1'b0;
      end

      // The vector stops on the last index so it holds there once the sweep ends.
      if (w_start_sweep) begin
        r_vec <= '0;
      end else if (r_state == ST_RUN && !w_last && !abort) begin
        r_vec <= r_vec + N_IN'(1);
      end

      // Counts remaining drain cycles minus one, loaded while still running.
      if (r_state == ST_RUN) begin
        r_drain_cnt <= DW'(PIPE - 1);
      end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
        r_drain_cnt <= r_drain_cnt - DW'(1);
      end

      if (w_start_sweep) begin
        r_onset    <= '0;
        r_mis      <= '0;
        r_mismatch <= 1'b0;
        r_first    <= '0;
      end else if (w_cap_valid) begin
        r_onset <= r_onset + CW'(y_a_i);
        r_mis   <= r_mis + CW'(w_diff);
        if (w_diff && !r_mismatch) begin
          r_mismatch <= 1'b1;
          r_first    <= w_cap_index;
        end
      end
    end
  end

  tt_tag_pipe #(
    .DEPTH (PIPE),
    .W     (N_IN)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_valid (w_tag_valid),
    .i_index (r_vec),
    .o_valid (w_cap_valid),
    .o_index (w_cap_index)
  );

  assign vec_o     = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign res_valid = r_res_valid;
  assign onset_cnt = r_onset;
  assign mis_cnt   = r_mis;
  assign mismatch  = r_mismatch;
  assign first_mis = r_first;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench: one combinational-path controller and one with a 2-stage netlist delay.
module tb_tt_sweep_ctrl;

  localparam int N = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start0, abort0, start2, abort2;
  logic [N-1:0] vec0, vec2;
  logic         ya0, yb0, ya2, yb2;
  logic         busy0, done0, rv0, mm0;
  logic         busy2, done2, rv2, mm2;
  logic [N:0]   on0, mis0, on2, mis2;
  logic [N-1:0] fm0, fm2;

  int     mode0  = 0;
  longint cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  int     done_cnt0 = 0;
  int     done_cnt2 = 0;
  logic   d1a = 1'b0, d2a = 1'b0, d1b = 1'b0, d2b = 1'b0;

  typedef struct {
    int     onset;
    int     mis;
    logic   mm;
    int     first;
    longint at;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;

  function automatic logic fa(input int m, input logic [N-1:0] v);
    if (m == 2) return v[1] & v[2];
    return v[0];
  endfunction

  function automatic logic fb(input int m, input logic [N-1:0] v);
    case (m)
      0:       return v[0];
      1:       return v[0] ^ ((v == 7'h55) || (v == 7'h70));
      default: return fa(m, v) ^ (v >= 7'd100);
    endcase
  endfunction

  assign ya0 = fa(mode0, vec0);
  assign yb0 = fb(mode0, vec0);

  // Two-stage registered netlist model: A is constant 1, B differs only at 0x7F.
  always @(posedge clk) begin
    d1a <= 1'b1;
    d1b <= (vec2 != 7'h7F);
    d2a <= d1a;
    d2b <= d1b;
  end
  assign ya2 = d2a;
  assign yb2 = d2b;

  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_ctrl #(.N_IN(N), .PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .vec_o(vec0),
    .y_a_i(ya0), .y_b_i(yb0), .busy(busy0), .done(done0), .res_valid(rv0),
    .onset_cnt(on0), .mis_cnt(mis0), .mismatch(mm0), .first_mis(fm0)
  );

  tt_sweep_ctrl #(.N_IN(N), .PIPE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .vec_o(vec2),
    .y_a_i(ya2), .y_b_i(yb2), .busy(busy2), .done(done2), .res_valid(rv2),
    .onset_cnt(on2), .mis_cnt(mis2), .mismatch(mm2), .first_mis(fm2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done0();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut0_done_timeout: got no done, expected done within 400 cycles");
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done0 === 1'b1) begin
      done_cnt0++;
      chk("dut0_done_expected", 64'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("dut0_onset",     on0,  e0.onset);
        chk("dut0_mis_cnt",   mis0, e0.mis);
        chk("dut0_mismatch",  mm0,  e0.mm);
        chk("dut0_first_mis", fm0,  e0.first);
        chk("dut0_res_valid", rv0,  1);
        chk("dut0_done_cycle", cyc, e0.at);
        $display("dut0 sweep done: cycle=%0d onset=%0d mis=%0d first=0x%0h", cyc, on0, mis0, fm0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done2 === 1'b1) begin
      done_cnt2++;
      chk("dut2_done_expected", 64'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk("dut2_onset",     on2,  e2.onset);
        chk("dut2_mis_cnt",   mis2, e2.mis);
        chk("dut2_mismatch",  mm2,  e2.mm);
        chk("dut2_first_mis", fm2,  e2.first);
        chk("dut2_res_valid", rv2,  1);
        chk("dut2_done_cycle", cyc, e2.at);
        $display("dut2 sweep done: cycle=%0d onset=%0d mis=%0d first=0x%0h", cyc, on2, mis2, fm2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    start0 = 1'b1;
    start2 = 1'b1;
    abort0 = 1'b0;
    abort2 = 1'b0;
    mode0  = 0;
    repeat (3) @(negedge clk);
    chk("rst_vec0", vec0, 0);       chk("rst_vec2", vec2, 0);
    chk("rst_busy0", busy0, 0);     chk("rst_busy2", busy2, 0);
    chk("rst_done0", done0, 0);     chk("rst_done2", done2, 0);
    chk("rst_rv0", rv0, 0);         chk("rst_rv2", rv2, 0);
    chk("rst_onset0", on0, 0);      chk("rst_onset2", on2, 0);
    chk("rst_mis0", mis0, 0);       chk("rst_mis2", mis2, 0);
    chk("rst_mm0", mm0, 0);         chk("rst_mm2", mm2, 0);
    chk("rst_first0", fm0, 0);      chk("rst_first2", fm2, 0);

    rst_n  = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy0", busy0, 0);
    chk("idle_busy2", busy2, 0);
    chk("idle_no_done0", done_cnt0, 0);
    chk("idle_vec0", vec0, 0);

    // Identity sweep with a start pulse mid-run that must be ignored
    start0 = 1'b1;
    q0.push_back('{onset: 64, mis: 0, mm: 1'b0, first: 0, at: cyc + 129});
    @(negedge clk);
    start0 = 1'b0;
    chk("first_vec0", vec0, 0);
    chk("busy0_cycle1", busy0, 1);
    repeat (9) @(negedge clk);
    chk("vec0_cycle10", vec0, 9);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("vec0_after_run_start", vec0, 10);
    repeat (117) @(negedge clk);
    chk("last_vec0", vec0, 127);
    chk("busy0_cycle128", busy0, 1);
    wait_done0();

    // Start in the DONE cycle restarts with fault-injected netlist B
    mode0  = 1;
    start0 = 1'b1;
    q0.push_back('{onset: 64, mis: 2, mm: 1'b1, first: 'h55, at: cyc + 129});
    @(negedge clk);
    start0 = 1'b0;
    chk("vec0_restart_from_done", vec0, 0);
    chk("busy0_restart", busy0, 1);
    chk("rv0_cleared_on_restart", rv0, 0);
    wait_done0();
    @(negedge clk);
    chk("done0_single_pulse", done0, 0);
    chk("rv0_hold", rv0, 1);
    chk("mis0_hold", mis0, 2);
    chk("first0_hold", fm0, 'h55);

    // Abort at cycle 50, then a full sweep of the same function
    mode0  = 2;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (49) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("busy0_after_abort", busy0, 0);
    chk("rv0_after_abort", rv0, 0);
    n = done_cnt0;
    repeat (150) @(negedge clk);
    chk("no_done_after_abort", done_cnt0, n);
    chk("busy0_idle_after_abort", busy0, 0);
    start0 = 1'b1;
    q0.push_back('{onset: 32, mis: 28, mm: 1'b1, first: 100, at: cyc + 129});
    @(negedge clk);
    start0 = 1'b0;
    wait_done0();

    // Pipelined instance: drain adds two cycles and the final vector still counts
    start2 = 1'b1;
    q2.push_back('{onset: 128, mis: 1, mm: 1'b1, first: 'h7F, at: cyc + 131});
    @(negedge clk);
    start2 = 1'b0;
    chk("busy2_cycle1", busy2, 1);
    chk("vec2_cycle1", vec2, 0);
    repeat (129) @(negedge clk);
    chk("busy2_cycle130", busy2, 1);
    chk("done2_cycle130", done2, 0);
    @(negedge clk);
    chk("busy2_cycle131", busy2, 0);
    chk("done2_cycle131", done2, 1);
    @(negedge clk);
    chk("done2_single_pulse", done2, 0);
    chk("rv2_hold", rv2, 1);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("dut2_done_count", done_cnt2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
